// File: rtl/mix_pkg.sv
// MIX character set helpers shared by the card-reader input unit and the
// character output unit: word/char geometry, control bytes and the
// MIX <-> ASCII translation tables.
package mix_pkg;

  localparam int MIX_CHARS_PER_WORD = 5;
  localparam int MIX_CHAR_W         = 6;
  localparam int MIX_WORD_W         = 30;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_CR,
    S_LF,
    S_DONE
  } out_state_t;

  // MIX char code to printable ASCII; codes 56..63 have no glyph and print as '?'
  function automatic logic [7:0] mix2ascii(input logic [5:0] code);
    logic [7:0] c;
    logic [7:0] ascii;
    c     = {2'b00, code};
    ascii = 8'h3F;
    if (code == 6'd0)        ascii = 8'h20;
    else if (code <= 6'd9)   ascii = 8'h40 + c;
    else if (code == 6'd10)  ascii = 8'h7E;
    else if (code <= 6'd19)  ascii = 8'h3F + c;
    else if (code == 6'd20)  ascii = 8'h5B;
    else if (code == 6'd21)  ascii = 8'h5D;
    else if (code <= 6'd29)  ascii = 8'h3D + c;
    else if (code <= 6'd39)  ascii = 8'h12 + c;
    else begin
      case (code)
        6'd40:   ascii = 8'h2E;
        6'd41:   ascii = 8'h2C;
        6'd42:   ascii = 8'h28;
        6'd43:   ascii = 8'h29;
        6'd44:   ascii = 8'h2B;
        6'd45:   ascii = 8'h2D;
        6'd46:   ascii = 8'h2A;
        6'd47:   ascii = 8'h2F;
        6'd48:   ascii = 8'h3D;
        6'd49:   ascii = 8'h24;
        6'd50:   ascii = 8'h3C;
        6'd51:   ascii = 8'h3E;
        6'd52:   ascii = 8'h40;
        6'd53:   ascii = 8'h3B;
        6'd54:   ascii = 8'h3A;
        6'd55:   ascii = 8'h27;
        default: ascii = 8'h3F;
      endcase
    end
    return ascii;
  endfunction

  // ASCII to MIX char code for the input unit; characters it does not accept map to blank
  function automatic logic [5:0] ascii2mix(input logic [7:0] ch);
    logic [5:0] code;
    code = 6'd0;
    if (ch >= 8'h41 && ch <= 8'h49)      code = 6'(ch - 8'h40);
    else if (ch >= 8'h4A && ch <= 8'h52) code = 6'(ch - 8'h3F);
    else if (ch >= 8'h53 && ch <= 8'h5A) code = 6'(ch - 8'h3D);
    else if (ch >= 8'h30 && ch <= 8'h39) code = 6'(ch - 8'h12);
    else begin
      case (ch)
        8'h7E:   code = 6'd10;
        8'h5B:   code = 6'd20;
        8'h5D:   code = 6'd21;
        8'h2E:   code = 6'd40;
        8'h2C:   code = 6'd41;
        8'h28:   code = 6'd42;
        8'h29:   code = 6'd43;
        8'h2B:   code = 6'd44;
        8'h2D:   code = 6'd45;
        8'h2A:   code = 6'd46;
        8'h2F:   code = 6'd47;
        8'h3D:   code = 6'd48;
        8'h24:   code = 6'd49;
        8'h3C:   code = 6'd50;
        8'h3E:   code = 6'd51;
        8'h40:   code = 6'd52;
        8'h3B:   code = 6'd53;
        8'h3A:   code = 6'd54;
        8'h27:   code = 6'd55;
        default: code = 6'd0;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/out_unit_if.sv
// CPU-side port of the character output unit: the OUT command, the
// word-fetch handshake against CPU memory and the stall/busy status.
interface out_unit_if;
  import mix_pkg::*;

  logic                  start;
  logic [11:0]           addressin;
  logic [11:0]           addressout;
  logic                  request;
  logic                  load;
  logic [MIX_WORD_W-1:0] word;
  logic                  stop;
  logic                  busy;

  modport master (
    output start, addressin, load, word,
    input  addressout, request, stop, busy
  );

  modport slave (
    input  start, addressin, load, word,
    output addressout, request, stop, busy
  );

endinterface

// File: rtl/out_unit_uart_tx.sv
// 8N1 UART transmitter, LSB first. A byte is accepted when idle; the start
// bit begins the following cycle and ready returns once the stop bit ends.
module uart_tx #(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic             active;

  // Load a frame on accept, then shift one bit out every BAUD_DIV cycles until the stop bit ends
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      active   <= 1'b0;
    end else if (!active) begin
      if (tx_valid) begin
        shreg    <= {1'b1, tx_data, 1'b0};
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      shreg    <= {1'b1, shreg[9:1]};
      if (bit_cnt == 4'd9) begin
        active  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tx_ready = !active;
  assign tx       = active ? shreg[0] : 1'b1;

endmodule

// File: rtl/out_unit.sv
// MIX character output unit: fetches a block of words from CPU memory,
// unpacks each into five MIX chars, prints them as ASCII over the UART and
// ends every block with CR LF. One further OUT command may be queued.
module out_unit
  import mix_pkg::*;
#(
  parameter int BAUD_DIV    = 217,
  parameter int BLOCK_WORDS = 16
) (
  input  logic       clk,
  input  logic       reset,
  out_unit_if.slave  bus,
  output logic       tx
);

  localparam int WC_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BLOCK_WORDS - 1);
  localparam logic [2:0]      CC_LAST = 3'(MIX_CHARS_PER_WORD - 1);

  out_state_t state, state_next;

  logic [WC_W-1:0]       wc;
  logic [2:0]            cc;
  logic [MIX_WORD_W-1:0] shift;
  logic                  queued;
  logic [11:0]           queued_addr;
  logic [11:0]           addr_q;
  logic                  stop_q;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  logic        launch;
  logic [11:0] launch_addr;
  logic        take_word;
  logic        char_done;
  logic        word_done;
  logic        queue_start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state, UART byte selection and datapath strobes
  always_comb begin
    state_next  = state;
    tx_valid    = 1'b0;
    tx_data     = ASCII_CR;
    launch      = 1'b0;
    launch_addr = bus.addressin;
    take_word   = 1'b0;
    char_done   = 1'b0;
    word_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          launch     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.load) begin
          take_word  = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = mix2ascii(shift[MIX_WORD_W-1 -: MIX_CHAR_W]);
        if (tx_ready) begin
          char_done = 1'b1;
          if (cc == CC_LAST) begin
            word_done  = 1'b1;
            state_next = (wc == WC_LAST) ? S_CR : S_FETCH;
          end
        end
      end
      S_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
        if (tx_ready) state_next = S_LF;
      end
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (tx_ready) state_next = S_DONE;
      end
      S_DONE: begin
        if (tx_ready) begin
          if (queued) begin
            launch      = 1'b1;
            launch_addr = queued_addr;
            state_next  = S_FETCH;
          end else if (bus.start) begin
            launch     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    queue_start = bus.start && (state != S_IDLE) && !launch;
  end

  // Address, word/char counters, unpacking shift register and the one-deep command queue
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      stop_q      <= 1'b0;
      wc          <= '0;
      cc          <= '0;
      shift       <= '0;
      queued      <= 1'b0;
      queued_addr <= '0;
    end else begin
      stop_q <= launch;
      if (launch) begin
        addr_q <= launch_addr;
        wc     <= '0;
        queued <= 1'b0;
      end else if (queue_start && !queued) begin
        queued      <= 1'b1;
        queued_addr <= bus.addressin;
      end
      if (take_word) begin
        shift  <= bus.word;
        addr_q <= addr_q + 12'd1;
        cc     <= '0;
      end
      if (char_done) begin
        shift <= {shift[MIX_WORD_W-MIX_CHAR_W-1:0], {MIX_CHAR_W{1'b0}}};
        cc    <= cc + 3'd1;
      end
      if (word_done) wc <= wc + 1'b1;
    end
  end

  assign bus.request    = (state == S_FETCH);
  assign bus.busy       = (state != S_IDLE);
  assign bus.stop       = stop_q;
  assign bus.addressout = addr_q;

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx       (tx)
  );

endmodule

// File: tb/tb_out_unit.sv
// Bench for the MIX character output unit: a random-latency memory
// responder, a UART receiver and a table-driven model of the printed text.
module tb_out_unit;

  localparam int BAUD_DIV    = 4;
  localparam int BLOCK_WORDS = 16;
  localparam int FRAME       = 10 * BAUD_DIV;
  localparam int BLOCK_LIMIT = 200 * FRAME;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;

  out_unit_if bus();

  out_unit #(
    .BAUD_DIV    (BAUD_DIV),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int framing_err = 0;

  logic [29:0] mem [0:4095];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [11:0] addr_log[$];
  logic [11:0] exp_addr[$];
  logic [11:0] stop_addr[$];

  string mix_table = " ABCDEFGHI~JKLMNOPQR[]STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addressin = a;
    @(negedge clk);
    bus.start = 1'b0;
    bus.addressin = 12'($urandom);
  endtask

  function automatic logic [29:0] pack5(input int c0, input int c1, input int c2, input int c3, input int c4);
    return {6'(c0), 6'(c1), 6'(c2), 6'(c3), 6'(c4)};
  endfunction

  task automatic expectBlock(input logic [11:0] a);
    logic [11:0] adr;
    logic [29:0] wv;
    int code;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      adr = a + 12'(w);
      exp_addr.push_back(adr);
      wv = mem[adr];
      for (int c = 0; c < 5; c++) begin
        code = int'((wv >> (6 * (4 - c))) & 30'h3F);
        exp_q.push_back(8'(mix_table[code]));
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic compareStreams(input string tag);
    checkOutput({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    checkOutput({tag, "_naddr"}, 32'(addr_log.size()), 32'(exp_addr.size()));
    for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(exp_addr[i]));
    rx_q.delete();
    exp_q.delete();
    addr_log.delete();
    exp_addr.delete();
  endtask

  // UART receiver: samples each bit near its middle
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        logic [7:0] b;
        repeat (BAUD_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (BAUD_DIV) @(negedge clk);
        if (tx !== 1'b1) framing_err++;
        rx_q.push_back(b);
      end
    end
  end

  // Record the address presented with every stop pulse
  initial begin
    forever begin
      @(negedge clk);
      if (bus.stop === 1'b1) stop_addr.push_back(bus.addressout);
    end
  end

  // CPU memory: answers request after 0..3 cycles, sometimes pulses load unasked
  initial begin
    bus.load = 1'b0;
    bus.word = '0;
    forever begin
      @(negedge clk);
      if (bus.request === 1'b1 && reset === 1'b0) begin
        int d;
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        if (bus.request === 1'b1) begin
          bus.load = 1'b1;
          bus.word = mem[bus.addressout];
          addr_log.push_back(bus.addressout);
          @(negedge clk);
          bus.load = 1'b0;
          bus.word = 30'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.load = 1'b1;
        bus.word = 30'($urandom);
        @(negedge clk);
        bus.load = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0;
    int k;
    bus.start = 1'b0;
    bus.addressin = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 30'($urandom);

    // reset held for three cycles
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_stop", 32'(bus.stop), 32'd0);
    checkOutput("rst_request", 32'(bus.request), 32'd0);
    checkOutput("rst_addressout", 32'(bus.addressout), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_addressout", 32'(bus.addressout), 32'd0);
    checkOutput("idle_stops", 32'(stop_addr.size()), 32'd0);

    // one block at 100, first word prints ABCDE
    mem[100] = pack5(1, 2, 3, 4, 5);
    expectBlock(12'd100);
    n0 = stop_addr.size();
    applyStimulus(12'd100);
    @(negedge clk);
    checkOutput("t2_stop_count", 32'(stop_addr.size()), 32'(n0 + 1));
    checkOutput("t2_stop_addr", 32'(stop_addr[$]), 32'd100);
    checkOutput("t2_stop_width", 32'(bus.stop), 32'd0);
    checkOutput("t2_busy", 32'(bus.busy), 32'd1);
    waitIdle("t2", BLOCK_LIMIT);
    checkOutput("t2_stop_once", 32'(stop_addr.size()), 32'(n0 + 1));
    checkOutput("t2_addr0", 32'(addr_log[0]), 32'd100);
    checkOutput("t2_addr1", 32'(addr_log[1]), 32'd101);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("t2_abcde%0d", i), 32'(rx_q[i]), 32'(8'h41 + i));
    compareStreams("t2");

    // all-zero block at 3000 prints 80 blanks then CR LF
    for (int i = 0; i < 16; i++) mem[3000 + i] = '0;
    expectBlock(12'd3000);
    applyStimulus(12'd3000);
    waitIdle("t3", BLOCK_LIMIT);
    checkOutput("t3_last", 32'(rx_q[$]), 32'h0A);
    checkOutput("t3_blank79", 32'(rx_q[79]), 32'h20);
    checkOutput("t3_addr15", 32'(addr_log[15]), 32'd3015);
    compareStreams("t3");

    // address wraps from 4095 to 0
    expectBlock(12'd4094);
    applyStimulus(12'd4094);
    waitIdle("t4", BLOCK_LIMIT);
    checkOutput("t4_addr1", 32'(addr_log[1]), 32'd4095);
    checkOutput("t4_addr2", 32'(addr_log[2]), 32'd0);
    compareStreams("t4");

    // second command queued during word 5, third ignored
    expectBlock(12'd500);
    expectBlock(12'd200);
    n0 = stop_addr.size();
    applyStimulus(12'd500);
    k = 0;
    while (addr_log.size() < 5 && k < BLOCK_LIMIT) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5_reach_word5", 32'(addr_log.size() >= 5), 32'd1);
    applyStimulus(12'd200);
    repeat (3) @(negedge clk);
    checkOutput("t5_no_early_stop", 32'(stop_addr.size()), 32'(n0 + 1));
    repeat (3 * FRAME) @(negedge clk);
    applyStimulus(12'd300);
    k = 0;
    while (stop_addr.size() < n0 + 2 && k < BLOCK_LIMIT) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5_second_stop", 32'(stop_addr.size()), 32'(n0 + 2));
    checkOutput("t5_rx_at_stop", 32'(rx_q.size()), 32'(5 * BLOCK_WORDS + 2));
    checkOutput("t5_lf_at_stop", 32'(rx_q[$]), 32'h0A);
    checkOutput("t5_stop_addr", 32'(stop_addr[$]), 32'd200);
    checkOutput("t5_busy_kept", 32'(bus.busy), 32'd1);
    waitIdle("t5", 2 * BLOCK_LIMIT);
    repeat (20) @(negedge clk);
    checkOutput("t5_third_ignored", 32'(bus.busy), 32'd0);
    checkOutput("t5_stop_total", 32'(stop_addr.size()), 32'(n0 + 2));
    compareStreams("t5");

    // special codes, then reset during a frame's start bit
    mem[600] = pack5(30, 52, 63, 10, 55);
    applyStimulus(12'd600);
    k = 0;
    while (rx_q.size() < 2 && k < BLOCK_LIMIT) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t6_char0", 32'(rx_q[0]), 32'h30);
    checkOutput("t6_char1", 32'(rx_q[1]), 32'h40);
    k = 0;
    while (tx !== 1'b0 && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t6_in_start_bit", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_reset_tx", 32'(tx), 32'd1);
    checkOutput("t6_reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("t6_reset_request", 32'(bus.request), 32'd0);
    reset = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    checkOutput("t6_quiet_after_reset", 32'(bus.busy), 32'd0);
    rx_q.delete();
    addr_log.delete();
    expectBlock(12'd600);
    applyStimulus(12'd600);
    waitIdle("t6", BLOCK_LIMIT);
    checkOutput("t6_re0", 32'(rx_q[0]), 32'h30);
    checkOutput("t6_re1", 32'(rx_q[1]), 32'h40);
    checkOutput("t6_re2", 32'(rx_q[2]), 32'h3F);
    checkOutput("t6_re3", 32'(rx_q[3]), 32'h7E);
    checkOutput("t6_re4", 32'(rx_q[4]), 32'h27);
    compareStreams("t6");

    checkOutput("framing", 32'(framing_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
